// File: rtl/key_conditioner.sv
// Pushbutton conditioner: per-key 2-flop synchronizer and 4-state debounce FSM with press/release strobes.
// Define KEY_COND_REPEAT_EN to auto-repeat press_pulse every REPEAT_CYCLES while a key stays held.
module key_conditioner_ch #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_CYCLES   = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic i_key_n,
   output logic o_pressed,
   output logic o_press_pulse,
   output logic o_release_pulse
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   // The D-th stable sample is the one that commits, so the stored count tops out at D-1.
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

   if (DEBOUNCE_CYCLES < 2) begin : g_bad_db
      $error("DEBOUNCE_CYCLES must be >= 2");
   end
   if (REPEAT_CYCLES < 2) begin : g_bad_rpt
      $error("REPEAT_CYCLES must be >= 2");
   end

   state_t        r_state;
   logic [1:0]    r_sync;
   logic [CW-1:0] r_cnt;
   logic          r_pressed;
   logic          r_press_pulse;
   logic          r_release_pulse;
   logic          w_down;

   assign w_down = ~r_sync[1];

`ifdef KEY_COND_REPEAT_EN
   localparam int RW = $clog2(REPEAT_CYCLES);
   localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
   logic [RW-1:0] r_rpt;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync          <= 2'b11;
         r_state         <= RELEASED;
         r_cnt           <= '0;
         r_pressed       <= 1'b0;
         r_press_pulse   <= 1'b0;
         r_release_pulse <= 1'b0;
`ifdef KEY_COND_REPEAT_EN
         r_rpt           <= '0;
`endif
      end else begin
         r_sync          <= {r_sync[0], i_key_n};
         r_press_pulse   <= 1'b0;
         r_release_pulse <= 1'b0;
         case (r_state)
            RELEASED: begin
               if (w_down) begin
                  r_state <= PRESS_WAIT;
                  r_cnt   <= CW'(1);
               end
            end
            PRESS_WAIT: begin
               if (!w_down) begin
                  r_state <= RELEASED;
                  r_cnt   <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_state       <= PRESSED;
                  r_cnt         <= '0;
                  r_pressed     <= 1'b1;
                  r_press_pulse <= 1'b1;
`ifdef KEY_COND_REPEAT_EN
                  r_rpt         <= '0;
`endif
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            PRESSED: begin
               if (!w_down) begin
                  r_state <= RELEASE_WAIT;
                  r_cnt   <= CW'(1);
`ifdef KEY_COND_REPEAT_EN
                  r_rpt   <= '0;
               end else if (r_rpt == RPT_LAST) begin
                  r_rpt         <= '0;
                  r_press_pulse <= 1'b1;
               end else begin
                  r_rpt <= r_rpt + 1'b1;
`endif
               end
            end
            RELEASE_WAIT: begin
               if (w_down) begin
                  r_state <= PRESSED;
                  r_cnt   <= '0;
`ifdef KEY_COND_REPEAT_EN
                  r_rpt   <= '0;
`endif
               end else if (r_cnt == CNT_LAST) begin
                  r_state         <= RELEASED;
                  r_cnt           <= '0;
                  r_pressed       <= 1'b0;
                  r_release_pulse <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= RELEASED;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign o_pressed       = r_pressed;
   assign o_press_pulse   = r_press_pulse;
   assign o_release_pulse = r_release_pulse;
endmodule

module key_conditioner #(
   parameter int NUM_KEYS        = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_CYCLES   = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic [NUM_KEYS-1:0] pressed,
   output logic [NUM_KEYS-1:0] press_pulse,
   output logic [NUM_KEYS-1:0] release_pulse
);
   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
      key_conditioner_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_CYCLES   (REPEAT_CYCLES)
      ) u_ch (
         .clk             (clk),
         .reset           (reset),
         .i_key_n         (key_n[g]),
         .o_pressed       (pressed[g]),
         .o_press_pulse   (press_pulse[g]),
         .o_release_pulse (release_pulse[g])
      );
   end
endmodule

// File: tb/tb_key_conditioner.sv
// Cycle-vector bench for key_conditioner (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8, NUM_KEYS=4).
// Expected outputs per edge come from the 2-flop + D-sample latency of the requirements.
module tb_key_conditioner;
   localparam int NK = 4;
   localparam int DB = 4;
   localparam int RP = 8;
`ifdef KEY_COND_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [NK-1:0] key_n;
   logic [NK-1:0] pressed, press_pulse, release_pulse;

   typedef struct {
      bit         rst;
      logic [3:0] kn;
      logic [3:0] p;
      logic [3:0] pp;
      logic [3:0] rp;
      string      name;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   checks = 0;
   int   errors = 0;

   key_conditioner #(
      .NUM_KEYS        (NK),
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_CYCLES   (RP)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .key_n         (key_n),
      .pressed       (pressed),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse)
   );

   always #5 clk = ~clk;

   task automatic add(input int n, input bit rst, input logic [3:0] kn, input logic [3:0] p,
                      input logic [3:0] pp, input logic [3:0] rp, input string nm);
      vec_t v;
      v.rst = rst; v.kn = kn; v.p = p; v.pp = pp; v.rp = rp; v.name = nm;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %b want %b", nm, idx, act, exp);
      end
   endtask

   initial begin
      vec_t e;
      reset = 1'b1;
      key_n = '1;

      // reset state and idle
      add(2, 1, 4'hF, 4'h0, 4'h0, 4'h0, "reset");
      add(3, 0, 4'hF, 4'h0, 4'h0, 4'h0, "idle");
      // clean press on key 0: pressed rises after edge 6, then clean release
      add(5, 0, 4'hE, 4'h0, 4'h0, 4'h0, "press0_wait");
      add(1, 0, 4'hE, 4'h1, 4'h1, 4'h0, "press0_rise");
      add(3, 0, 4'hE, 4'h1, 4'h0, 4'h0, "press0_hold");
      add(5, 0, 4'hF, 4'h1, 4'h0, 4'h0, "rel0_wait");
      add(1, 0, 4'hF, 4'h0, 4'h0, 4'h1, "rel0_fall");
      add(2, 0, 4'hF, 4'h0, 4'h0, 4'h0, "rel0_idle");
      // bounce reject on key 1: only 3 low samples
      add(3, 0, 4'hD, 4'h0, 4'h0, 4'h0, "bounce1_low");
      add(8, 0, 4'hF, 4'h0, 4'h0, 4'h0, "bounce1_high");
      // key 2: press, then release with a one-cycle bounce
      add(5, 0, 4'hB, 4'h0, 4'h0, 4'h0, "press2_wait");
      add(1, 0, 4'hB, 4'h4, 4'h4, 4'h0, "press2_rise");
      add(2, 0, 4'hB, 4'h4, 4'h0, 4'h0, "press2_hold");
      add(2, 0, 4'hF, 4'h4, 4'h0, 4'h0, "rel2_high");
      add(1, 0, 4'hB, 4'h4, 4'h0, 4'h0, "rel2_bounce");
      add(5, 0, 4'hF, 4'h4, 4'h0, 4'h0, "rel2_wait");
      add(1, 0, 4'hF, 4'h0, 4'h0, 4'h4, "rel2_fall");
      add(2, 0, 4'hF, 4'h0, 4'h0, 4'h0, "rel2_idle");
      // key 3 held, reset mid-wait, then accepted as a new press
      add(4, 0, 4'h7, 4'h0, 4'h0, 4'h0, "press3_wait");
      add(2, 1, 4'h7, 4'h0, 4'h0, 4'h0, "press3_reset");
      add(5, 0, 4'h7, 4'h0, 4'h0, 4'h0, "press3_rewait");
      add(1, 0, 4'h7, 4'h8, 4'h8, 4'h0, "press3_rise");
      add(2, 0, 4'h7, 4'h8, 4'h0, 4'h0, "press3_hold");
      add(5, 0, 4'hF, 4'h8, 4'h0, 4'h0, "rel3_wait");
      add(1, 0, 4'hF, 4'h0, 4'h0, 4'h8, "rel3_fall");
      add(2, 0, 4'hF, 4'h0, 4'h0, 4'h0, "rel3_idle");
      // reset while pressed: no release pulse
      add(5, 0, 4'hE, 4'h0, 4'h0, 4'h0, "midp_wait");
      add(1, 0, 4'hE, 4'h1, 4'h1, 4'h0, "midp_rise");
      add(1, 0, 4'hE, 4'h1, 4'h0, 4'h0, "midp_hold");
      add(2, 1, 4'hF, 4'h0, 4'h0, 4'h0, "midp_reset");
      add(4, 0, 4'hF, 4'h0, 4'h0, 4'h0, "midp_after");
      // all keys on the same edge
      add(5, 0, 4'h0, 4'h0, 4'h0, 4'h0, "all_wait");
      add(1, 0, 4'h0, 4'hF, 4'hF, 4'h0, "all_rise");
      add(3, 0, 4'h0, 4'hF, 4'h0, 4'h0, "all_hold");
      add(5, 0, 4'hF, 4'hF, 4'h0, 4'h0, "all_relwait");
      add(1, 0, 4'hF, 4'h0, 4'h0, 4'hF, "all_fall");
      add(2, 0, 4'hF, 4'h0, 4'h0, 4'h0, "all_idle");
      // key 0 held 30 cycles past its press pulse; the channel stays in PRESSED
      // two further edges after key_n rises, so edge c=32 still repeats
      add(5, 0, 4'hE, 4'h0, 4'h0, 4'h0, "rpt_wait");
      add(1, 0, 4'hE, 4'h1, 4'h1, 4'h0, "rpt_rise");
      for (int c = 1; c <= 38; c++) begin
         add(1, 0, (c <= 30) ? 4'hE : 4'hF,
             (c < 36) ? 4'h1 : 4'h0,
             (REP && c <= 32 && (c % RP) == 0) ? 4'h1 : 4'h0,
             (c == 36) ? 4'h1 : 4'h0, "rpt_hold");
      end
      add(2, 0, 4'hF, 4'h0, 4'h0, 4'h0, "rpt_idle");

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         reset = vecs[i].rst;
         key_n = vecs[i].kn;
         sb.push_back(vecs[i]);
         @(posedge clk);
         #1;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty vec %0d: got 0 entries want 1", i);
         end else begin
            e = sb.pop_front();
            chk({e.name, "_pressed"}, i, pressed, e.p);
            chk({e.name, "_press_pulse"}, i, press_pulse, e.pp);
            chk({e.name, "_release_pulse"}, i, release_pulse, e.rp);
            chk({e.name, "_pulse_overlap"}, i, press_pulse & release_pulse, 4'h0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
